// File: rtl/io_route_scheduler.sv
// io_route_scheduler: round-robin owner of the shared 1024:1 mux / 1:1024 demux
// routing path. Sequences IDLE -> SETUP -> ACTIVE -> RELEASE per granted route.
// Optional feature macro: IO_ROUTE_SCRAMBLE_EN (per-grant LFSR scrambling of mux_sel
// via com_sel; datapath select mux_sel ^ com_sel still equals the requested source).
module io_route_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SEL_W     = 10,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned DST_LIMIT = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEL_W-1:0] req_src,
  input  logic [NUM_REQ*SEL_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       req_err,
  output logic                     route_valid,
  output logic                     busy,
  output logic [SEL_W-1:0]         mux_sel,
  output logic [SEL_W-1:0]         demux_sel,
  output logic [3:0]               com_sel
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [SEL_W:0] DST_LIM = (SEL_W+1)'(DST_LIMIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] req_err_q, req_err_d;
  logic               route_valid_q, route_valid_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   mux_sel_q, mux_sel_d;
  logic [SEL_W-1:0]   demux_sel_q, demux_sel_d;

  logic [SEL_W-1:0]   src_a [NUM_REQ];
  logic [SEL_W-1:0]   dst_a [NUM_REQ];
  logic               found;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      pick_next;
  logic [IW:0]        sum;
  logic [IW:0]        nxt;

  // Unpack flat per-requester route indices
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign src_a[i] = req_src[i*SEL_W +: SEL_W];
    assign dst_a[i] = req_dst[i*SEL_W +: SEL_W];
  end

  // Round-robin search starting at the pointer; also the pointer value after a pick
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = (IW+1)'(ptr_q) + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
    nxt       = (IW+1)'(pick) + (IW+1)'(1);
    pick_next = (nxt == (IW+1)'(NUM_REQ)) ? '0 : nxt[IW-1:0];
  end

`ifdef IO_ROUTE_SCRAMBLE_EN
  logic [3:0] lfsr_q, lfsr_d;
  logic [3:0] com_sel_q, com_sel_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    gnt_d         = gnt_q;
    req_err_d     = '0;
    route_valid_d = route_valid_q;
    mux_sel_d     = mux_sel_q;
    demux_sel_d   = demux_sel_q;
`ifdef IO_ROUTE_SCRAMBLE_EN
    lfsr_d        = lfsr_q;
    com_sel_d     = com_sel_q;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d         = '0;
        route_valid_d = 1'b0;
        if (found) begin
          ptr_d = pick_next;
          if ({1'b0, dst_a[pick]} >= DST_LIM) begin
            req_err_d[pick] = 1'b1;
          end else begin
            state_d     = SETUP;
            gnt_d       = NUM_REQ'(1) << pick;
            gidx_d      = pick;
            cnt_d       = '0;
            demux_sel_d = dst_a[pick];
`ifdef IO_ROUTE_SCRAMBLE_EN
            com_sel_d   = lfsr_q;
            mux_sel_d   = src_a[pick] ^ SEL_W'(lfsr_q);
            lfsr_d      = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
`else
            mux_sel_d   = src_a[pick];
`endif
          end
        end
      end
      SETUP: begin
        if (!req[gidx_q]) begin
          state_d       = RELEASE;
          gnt_d         = '0;
          route_valid_d = 1'b0;
        end else if (cnt_q == CW'(SETTLE - 1)) begin
          state_d       = ACTIVE;
          route_valid_d = 1'b1;
          hold_d        = HW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACTIVE: begin
        if (!req[gidx_q] || (hold_q == HW'(MAX_HOLD) && |(req & ~gnt_q))) begin
          state_d       = RELEASE;
          gnt_d         = '0;
          route_valid_d = 1'b0;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      RELEASE: begin
        state_d       = IDLE;
        gnt_d         = '0;
        route_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gidx_q        <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      gnt_q         <= '0;
      req_err_q     <= '0;
      route_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      mux_sel_q     <= '0;
      demux_sel_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gidx_q        <= gidx_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      gnt_q         <= gnt_d;
      req_err_q     <= req_err_d;
      route_valid_q <= route_valid_d;
      busy_q        <= busy_d;
      mux_sel_q     <= mux_sel_d;
      demux_sel_q   <= demux_sel_d;
    end
  end

`ifdef IO_ROUTE_SCRAMBLE_EN
  // Scramble LFSR (x^4+x^3+1) and latched common select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q    <= 4'b0001;
      com_sel_q <= 4'b0000;
    end else begin
      lfsr_q    <= lfsr_d;
      com_sel_q <= com_sel_d;
    end
  end
  assign com_sel = com_sel_q;
`else
  assign com_sel = 4'b0000;
`endif

  assign gnt         = gnt_q;
  assign req_err     = req_err_q;
  assign route_valid = route_valid_q;
  assign busy        = busy_q;
  assign mux_sel     = mux_sel_q;
  assign demux_sel   = demux_sel_q;

endmodule

// File: tb/tb_io_route_scheduler.sv
// Directed testbench for io_route_scheduler (default parameters, scramble disabled).
module tb_io_route_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 10;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*SEL_W-1:0] req_src;
  logic [NUM_REQ*SEL_W-1:0] req_dst;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       req_err;
  logic                     route_valid;
  logic                     busy;
  logic [SEL_W-1:0]         mux_sel;
  logic [SEL_W-1:0]         demux_sel;
  logic [3:0]               com_sel;

  int checks   = 0;
  int failures = 0;

  io_route_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .gnt        (gnt),
    .req_err    (req_err),
    .route_valid(route_valid),
    .busy       (busy),
    .mux_sel    (mux_sel),
    .demux_sel  (demux_sel),
    .com_sel    (com_sel)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_route(input int i, input int src, input int dst);
    req_src[i*SEL_W +: SEL_W] = SEL_W'(src);
    req_dst[i*SEL_W +: SEL_W] = SEL_W'(dst);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for any grant to appear
  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (gnt == '0 && n < 10) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 10), 32'd1);
  endtask

  initial begin
    int n;
    int r;
    req     = '0;
    req_src = '0;
    req_dst = '0;
    rst_n   = 1'b0;
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_err", 32'(req_err), 32'h0);
    check("rst_rv", 32'(route_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mux", 32'(mux_sel), 32'h0);
    check("rst_demux", 32'(demux_sel), 32'h0);
    check("rst_com", 32'(com_sel), 32'h0);
    tick();
    rst_n = 1'b1;

    // Basic route: grant, settle, active, release
    set_route(0, 5, 7);
    req = 4'b0001;
    tick();
    check("s1_gnt", 32'(gnt), 32'h1);
    check("s1_mux", 32'(mux_sel), 32'd5);
    check("s1_demux", 32'(demux_sel), 32'd7);
    check("s1_busy", 32'(busy), 32'h1);
    check("s1_rv_setup0", 32'(route_valid), 32'h0);
    set_route(0, 9, 11);
    tick();
    check("s1_rv_setup1", 32'(route_valid), 32'h0);
    tick();
    check("s1_rv_active", 32'(route_valid), 32'h1);
    check("s1_mux_latched", 32'(mux_sel), 32'd5);
    check("s1_demux_latched", 32'(demux_sel), 32'd7);
    req = 4'b0000;
    tick();
    check("s1_rel_gnt", 32'(gnt), 32'h0);
    check("s1_rel_rv", 32'(route_valid), 32'h0);
    check("s1_rel_busy", 32'(busy), 32'h1);
    check("s1_rel_mux_hold", 32'(mux_sel), 32'd5);
    tick();
    check("s1_idle_busy", 32'(busy), 32'h0);

    // All four requesting: rotation 0,1,2,3,0 with 16-cycle ACTIVE windows
    do_reset();
    for (int i = 0; i < 4; i++) set_route(i, i*10 + 1, i*10 + 2);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      r = g % 4;
      wait_gnt("s2_wait_gnt");
      check("s2_gnt", 32'(gnt), 32'(4'b0001 << r));
      check("s2_mux", 32'(mux_sel), 32'(r*10 + 1));
      tick();
      tick();
      n = 0;
      while (route_valid && n < 40) begin
        n++;
        tick();
      end
      check("s2_active_len", 32'(n), 32'd16);
      check("s2_rel_gnt", 32'(gnt), 32'h0);
      check("s2_rel_busy", 32'(busy), 32'h1);
      tick();
      check("s2_idle_busy", 32'(busy), 32'h0);
    end

    // Illegal destination: error pulse, no grant, next requester served
    do_reset();
    set_route(1, 3, 1000);
    set_route(2, 4, 999);
    req = 4'b0110;
    tick();
    check("s3_err", 32'(req_err), 32'h2);
    check("s3_err_gnt", 32'(gnt), 32'h0);
    tick();
    check("s3_err_clr", 32'(req_err), 32'h0);
    check("s3_gnt2", 32'(gnt), 32'h4);
    check("s3_demux", 32'(demux_sel), 32'd999);
    req = 4'b0000;
    tick();
    tick();
    check("s3_idle", 32'(busy), 32'h0);

    // Request dropped during SETUP: route_valid never asserts
    do_reset();
    set_route(0, 5, 7);
    req = 4'b0001;
    tick();
    check("s4_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    check("s4_rel_rv", 32'(route_valid), 32'h0);
    check("s4_rel_gnt", 32'(gnt), 32'h0);
    check("s4_rel_busy", 32'(busy), 32'h1);
    tick();
    check("s4_idle_rv", 32'(route_valid), 32'h0);
    check("s4_idle_busy", 32'(busy), 32'h0);

    // Asynchronous reset mid-route, then re-grant
    do_reset();
    set_route(0, 5, 7);
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("s5_rv_pre", 32'(route_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("s5_async_gnt", 32'(gnt), 32'h0);
    check("s5_async_rv", 32'(route_valid), 32'h0);
    check("s5_async_busy", 32'(busy), 32'h0);
    check("s5_async_mux", 32'(mux_sel), 32'h0);
    check("s5_async_demux", 32'(demux_sel), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("s5_regnt", 32'(gnt), 32'h1);
    check("s5_regnt_mux", 32'(mux_sel), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
